reset_sequencer: RTL and testbench

- Generates the asynchronous-assert, synchronous-release active-low resets consumed by downstream flops.
- Combines three reset sources into a staggered, in-order release of NUM_OUT reset outputs:
  - power-on reset (port reset)
  - debounced external reset pin
  - software reset request
- Sits at the top of each clock domain, ahead of all register banks.

---
 rtl/reset_sequencer.sv | 176 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges POR, debounced external pin and software request into staggered active-low resets.
// Latency: outputs assert on the edge a reset event is seen (immediately for POR); bit k releases HOLD+STAGGER*(k+1) cycles after sources are clean.
// Backpressure: none; free-running, every request is acted on in the cycle it is sampled.
module reset_sequencer #(
  parameter int NUM_OUT         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter int STAGGER_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ext_rst_n,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               rst_done,
  output logic [1:0]         rst_cause
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int IW = $clog2(NUM_OUT + 1);

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_EXT = 2'b10;
  localparam logic [1:0] CAUSE_SW  = 2'b11;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // external pin synchronizer and debouncer
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_s;
  logic                   ext_ok;
  logic                   ext_ok_d;
  logic [DW-1:0]          deb_cnt;
  logic [DW-1:0]          deb_cnt_d;
  logic                   ext_fall;

  // sequencing FSM
  state_t                 state;
  state_t                 state_d;
  logic [HW-1:0]          hold_cnt;
  logic [HW-1:0]          hold_cnt_d;
  logic [SW-1:0]          stg_cnt;
  logic [SW-1:0]          stg_cnt_d;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          idx_d;
  logic [NUM_OUT-1:0]     rst_out_n_d;
  logic                   rst_done_d;
  logic [1:0]             rst_cause_d;

  assign ext_s = sync_q[SYNC_STAGES-1];

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples, in either direction.
  always_comb begin
    ext_ok_d  = ext_ok;
    deb_cnt_d = '0;
    if (ext_s != ext_ok) begin
      if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        ext_ok_d = ext_s;
      end else begin
        deb_cnt_d = deb_cnt + DW'(1);
      end
    end
  end

  // A falling debounced level is acted on in the same edge that commits it, so outputs drop with ext_ok.
  assign ext_fall = ext_ok & ~ext_ok_d;

  // Synchronizer chain and debounce state; the debouncer runs independently of the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      ext_ok  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_rst_n};
      ext_ok  <= ext_ok_d;
      deb_cnt <= deb_cnt_d;
    end
  end

  // Next-state logic: hold until clean, release one bit per stagger period, abort on any new reset event.
  always_comb begin
    state_d     = state;
    hold_cnt_d  = hold_cnt;
    stg_cnt_d   = stg_cnt;
    idx_d       = idx;
    rst_out_n_d = rst_out_n;
    rst_done_d  = rst_done;
    rst_cause_d = rst_cause;
    case (state)
      HOLD: begin
        rst_out_n_d = '0;
        rst_done_d  = 1'b0;
        // A debounced fall here is still a reset event; it also blocks a release on the same edge.
        if (ext_fall) begin
          hold_cnt_d  = '0;
          rst_cause_d = CAUSE_EXT;
        end else if (sw_rst_req) begin
          hold_cnt_d  = '0;
          rst_cause_d = CAUSE_SW;
        end else if (!ext_ok) begin
          hold_cnt_d = '0;
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_d    = RELEASE;
          hold_cnt_d = '0;
          stg_cnt_d  = '0;
          idx_d      = '0;
        end else begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end
      RELEASE, RUN: begin
        if (ext_fall || sw_rst_req) begin
          state_d     = HOLD;
          rst_out_n_d = '0;
          rst_done_d  = 1'b0;
          hold_cnt_d  = '0;
          stg_cnt_d   = '0;
          idx_d       = '0;
          rst_cause_d = ext_fall ? CAUSE_EXT : CAUSE_SW;
        end else if (state == RELEASE) begin
          if (stg_cnt == SW'(STAGGER_CYCLES - 1)) begin
            stg_cnt_d = '0;
            for (int i = 0; i < NUM_OUT; i++) begin
              if (idx == IW'(i)) begin
                rst_out_n_d[i] = 1'b1;
              end
            end
            if (idx == IW'(NUM_OUT - 1)) begin
              state_d    = RUN;
              rst_done_d = 1'b1;
            end else begin
              idx_d = idx + IW'(1);
            end
          end else begin
            stg_cnt_d = stg_cnt + SW'(1);
          end
        end
      end
      default: begin
        state_d     = HOLD;
        rst_out_n_d = '0;
        rst_done_d  = 1'b0;
      end
    endcase
  end

  // FSM registers; every output is a flop, and POR forces them asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      stg_cnt   <= '0;
      idx       <= '0;
      rst_out_n <= '0;
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_cnt_d;
      stg_cnt   <= stg_cnt_d;
      idx       <= idx_d;
      rst_out_n <= rst_out_n_d;
      rst_done  <= rst_done_d;
      rst_cause <= rst_cause_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus an all-ones parameter corner, shared stimulus.
// Reference: per-config model counting debounce runs, hold cycles and time-since-release.
// Outputs sampled on the falling edge; inputs changed after sampling.
module tb_reset_sequencer;

  localparam int SYNC = 2;

  logic       clk;
  logic       reset;
  logic       ext_rst_n;
  logic       sw_rst_req;
  logic [3:0] out0;
  logic       done0;
  logic [1:0] cause0;
  logic [0:0] out1;
  logic       done1;
  logic [1:0] cause1;

  int n_vec;
  int n_err;
  int edge_no;

  reset_sequencer #(
    .NUM_OUT(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .HOLD_CYCLES(8), .STAGGER_CYCLES(4)
  ) dut0 (
    .clk(clk), .reset(reset), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .rst_out_n(out0), .rst_done(done0), .rst_cause(cause0)
  );

  reset_sequencer #(
    .NUM_OUT(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)
  ) dut1 (
    .clk(clk), .reset(reset), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .rst_out_n(out1), .rst_done(done1), .rst_cause(cause1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, act, exp, edge_no, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pnum(int c); return (c == 0) ? 4 : 1;  endfunction
  function automatic int pdeb(int c); return (c == 0) ? 16 : 1; endfunction
  function automatic int phold(int c); return (c == 0) ? 8 : 1; endfunction
  function automatic int pstg(int c); return (c == 0) ? 4 : 1;  endfunction

  bit m_sy   [2][SYNC];
  bit m_ok   [2];
  bit m_act  [2];
  int m_run  [2];
  int m_hold [2];
  int m_t    [2];
  int m_cause[2];

  task automatic model_reset(input int c);
    for (int i = 0; i < SYNC; i++) m_sy[c][i] = 1'b0;
    m_ok[c] = 1'b0; m_act[c] = 1'b0;
    m_run[c] = 0; m_hold[c] = 0; m_t[c] = 0; m_cause[c] = 1;
  endtask

  task automatic model_edge(input int c, input bit ext, input bit sw);
    bit es;
    bit ok_new;
    bit fall;
    es = m_sy[c][SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_sy[c][i] = m_sy[c][i-1];
    m_sy[c][0] = ext;
    ok_new = m_ok[c];
    if (es != m_ok[c]) begin
      m_run[c]++;
      if (m_run[c] == pdeb(c)) begin
        ok_new = es;
        m_run[c] = 0;
      end
    end else begin
      m_run[c] = 0;
    end
    fall = m_ok[c] && !ok_new;
    if (!m_act[c]) begin
      if (fall) begin m_hold[c] = 0; m_cause[c] = 2; end
      else if (sw) begin m_hold[c] = 0; m_cause[c] = 3; end
      else if (!m_ok[c]) m_hold[c] = 0;
      else begin
        m_hold[c]++;
        if (m_hold[c] == phold(c)) begin
          m_act[c] = 1'b1; m_t[c] = 0; m_hold[c] = 0;
        end
      end
    end else if (fall || sw) begin
      m_act[c] = 1'b0; m_hold[c] = 0; m_t[c] = 0;
      m_cause[c] = fall ? 2 : 3;
    end else if (m_t[c] < pnum(c) * pstg(c)) begin
      m_t[c]++;
    end
    m_ok[c] = ok_new;
  endtask

  function automatic int released(int c);
    int r;
    if (!m_act[c]) return 0;
    r = m_t[c] / pstg(c);
    if (r > pnum(c)) r = pnum(c);
    return r;
  endfunction

  function automatic logic [31:0] exp_out(int c);
    return (32'd1 << released(c)) - 32'd1;
  endfunction

  function automatic logic [31:0] exp_done(int c);
    return (m_act[c] && released(c) == pnum(c)) ? 32'd1 : 32'd0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    if (reset) begin
      edge_no++;
      model_edge(0, ext_rst_n, sw_rst_req);
      model_edge(1, ext_rst_n, sw_rst_req);
    end else begin
      model_reset(0);
      model_reset(1);
    end
    @(negedge clk);
    check("out0",   32'(out0),   exp_out(0));
    check("done0",  32'(done0),  exp_done(0));
    check("cause0", 32'(cause0), 32'(m_cause[0]));
    check("out1",   32'(out1),   exp_out(1));
    check("done1",  32'(done1),  exp_done(1));
    check("cause1", 32'(cause1), 32'(m_cause[1]));
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
  endtask

  // Counts edges until done0 is high; -1 when the budget runs out.
  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!done0 && n < max) begin step(); n++; end
    if (!done0) n = -1;
  endtask

  task automatic wait_out0(input logic [3:0] v, input int max, output int n);
    n = 0;
    while (out0 !== v && n < max) begin step(); n++; end
    if (out0 !== v) n = -1;
  endtask

  // Drops POR between clock edges and checks outputs before the next edge.
  task automatic por_pulse(input int low_cycles);
    #2 reset = 1'b0;
    #1;
    check("apor_out0",   32'(out0),   32'd0);
    check("apor_done0",  32'(done0),  32'd0);
    check("apor_cause0", 32'(cause0), 32'd1);
    check("apor_out1",   32'(out1),   32'd0);
    check("apor_cause1", 32'(cause1), 32'd1);
    model_reset(0);
    model_reset(1);
    repeat (low_cycles) step();
    reset = 1'b1;
    edge_no = 0;
  endtask

  int n;
  int hold_left;

  initial begin
    n_vec = 0; n_err = 0; edge_no = 0;
    reset = 1'b0; ext_rst_n = 1'b1; sw_rst_req = 1'b0;
    model_reset(0);
    model_reset(1);
    repeat (3) step();
    check("por_out0",   32'(out0),   32'd0);
    check("por_cause0", 32'(cause0), 32'd1);
    reset = 1'b1;
    edge_no = 0;

    // POR release timing against the documented edge numbers
    repeat (45) begin
      step();
      case (edge_no)
        4:  check("corner_e4_out", 32'(out1), 32'd0);
        5:  begin
              check("corner_e5_out",  32'(out1),  32'd1);
              check("corner_e5_done", 32'(done1), 32'd1);
            end
        29: check("e29_out", 32'(out0), 32'h0);
        30: check("e30_out", 32'(out0), 32'h1);
        34: check("e34_out", 32'(out0), 32'h3);
        38: check("e38_out", 32'(out0), 32'h7);
        41: check("e41_done", 32'(done0), 32'd0);
        42: begin
              check("e42_out",  32'(out0),  32'hF);
              check("e42_done", 32'(done0), 32'd1);
            end
        default: ;
      endcase
    end

    // short bounce is filtered
    ext_rst_n = 1'b0;
    repeat (10) step();
    ext_rst_n = 1'b1;
    repeat (30) step();
    check("bounce_done", 32'(done0), 32'd1);

    // long low: abort with EXT cause, then measured resequence
    ext_rst_n = 1'b0;
    repeat (20) step();
    check("ext_out", 32'(out0), 32'd0);
    check("ext_cause", 32'(cause0), 32'd2);
    ext_rst_n = 1'b1;
    wait_done(100, n);
    check("ext_reseq_edges", 32'(n), 32'd42);

    // software reset in RUN
    sw_pulse();
    check("sw_out", 32'(out0), 32'd0);
    check("sw_cause", 32'(cause0), 32'd3);
    wait_done(100, n);
    check("sw_reseq_edges", 32'(n), 32'd24);

    // abort mid-RELEASE
    sw_pulse();
    wait_out0(4'b0011, 100, n);
    check("sw_to_0011_edges", 32'(n), 32'd16);
    sw_pulse();
    check("midrel_out", 32'(out0), 32'd0);
    wait_done(100, n);
    check("midrel_reseq_edges", 32'(n), 32'd24);

    // debounced fall and sw request on the same edge
    ext_rst_n = 1'b0;
    repeat (17) step();
    check("pre_simul_done", 32'(done0), 32'd1);
    sw_pulse();
    check("simul_cause", 32'(cause0), 32'd2);
    check("simul_out", 32'(out0), 32'd0);
    ext_rst_n = 1'b1;
    wait_done(100, n);
    check("simul_reseq_edges", 32'(n), 32'd42);

    // async POR mid-RUN
    por_pulse(2);
    wait_done(100, n);
    check("por_reseq_edges", 32'(n), 32'd42);

    // randomized traffic
    hold_left = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (hold_left == 0) begin
        ext_rst_n = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
        hold_left = $urandom_range(1, 60);
      end
      hold_left--;
      sw_rst_req = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
      step();
      sw_rst_req = 1'b0;
      if ($urandom_range(0, 999) < 4) por_pulse($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
